// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer.
// Holds default frame geometry, derived bank depth/address width, the drop
// counter width and the writer state encoding.
package fb_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_H_PIXELS = 960;
  localparam int unsigned DEF_V_PIXELS = 540;
  localparam int unsigned DEF_DEPTH    = DEF_H_PIXELS * DEF_V_PIXELS;
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_DEPTH);
  localparam int unsigned DROP_CNT_W   = 16;

  // FILL: writer owns an empty bank; WAIT: both banks full, writer stalled.
  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } wr_state_t;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port synchronous RAM holding two banks of WORDS/2 words.
// The address MSB selects the bank, the lower bits the word inside the bank.
// One write port, one registered read port; read-first on a same-address
// collision. The read register can be cleared synchronously (rclr) so the
// caller can return zero for rejected reads, and it holds otherwise.
// Ports:
//   clk, rst_n       clock, async active-low reset (read register only)
//   we/waddr/wdata   write port
//   re/raddr         read port, data in rdata one cycle later
//   rclr             load zero into rdata (ignored when re=1)
//   rdata            registered read data
module dp_ram_sync #(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned WORDS      = 4,
  localparam int unsigned BANK_WORDS = WORDS / 2,
  localparam int unsigned OFF_W      = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1,
  localparam int unsigned AW         = OFF_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2][BANK_WORDS];

  // Storage array: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[AW-1]][waddr[OFF_W-1:0]] <= wdata;
    end
  end

  // Registered read; non-blocking read of mem gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr[AW-1]][raddr[OFF_W-1:0]];
    end else if (rclr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store between a pixel writer and a frame reader.
// The writer fills one bank while the reader scans the other; banks change
// hands on wr_frame_done / rd_frame_done. When no free bank exists the
// writer either stalls (DROP_MODE=0) or discards its frame and reuses its
// bank, counting the drop (DROP_MODE=1).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   wr_en, wr_addr, wr_data             pixel write (accepted when wr_ready)
//   wr_frame_done                       writer finished its bank
//   wr_ready                            writer may write
//   rd_en, rd_addr                      pixel read request
//   rd_data, rd_valid                   read response, one cycle later
//   rd_frame_done                       reader releases its bank
//   frame_avail                         reader's bank holds a complete frame
//   addr_err                            accepted access was out of range
//   drop_cnt                            saturating count of dropped frames
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned H_PIXELS  = DEF_H_PIXELS,
  parameter  int unsigned V_PIXELS  = DEF_V_PIXELS,
  parameter  int unsigned DROP_MODE = 0,
  localparam int unsigned DEPTH     = H_PIXELS * V_PIXELS,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_frame_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_frame_done,
  output logic                  frame_avail,
  output logic                  addr_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // One extra bit so DEPTH is representable even when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  wr_state_t             state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d, full_rel;
  logic [DROP_CNT_W-1:0] drop_d;
  logic                  wr_ready_d, addr_err_d;
  logic                  other;
  logic                  wr_oor, rd_oor, wr_acc, rd_rel;

  assign wr_oor = ({1'b0, wr_addr} >= DEPTH_X);
  assign rd_oor = ({1'b0, rd_addr} >= DEPTH_X);
  assign wr_acc = wr_en & wr_ready;
  assign rd_rel = rd_frame_done & full_q[rd_bank_q];

  // Reader-side view is unregistered so availability tracks the flags directly.
  assign frame_avail = full_q[rd_bank_q];

  // Writer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: reader release is applied first so the writer sees a bank
  // freed in the same cycle and never stalls on it.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_rel   = full_q;
    drop_d     = drop_cnt;
    other      = ~wr_bank_q;

    if (rd_rel) begin
      full_rel[rd_bank_q] = 1'b0;
      rd_bank_d           = ~rd_bank_q;
    end
    full_d = full_rel;

    case (state_q)
      FILL: begin
        if (wr_frame_done) begin
          full_d[wr_bank_q] = 1'b1;
          if (!full_rel[other]) begin
            wr_bank_d = other;
          end else if (DROP_MODE == 0) begin
            state_d = WAIT;
          end else begin
            // Discard the frame just written and refill the same bank.
            full_d[wr_bank_q] = 1'b0;
            if (drop_cnt != '1) begin
              drop_d = drop_cnt + DROP_CNT_W'(1);
            end
          end
        end
      end
      WAIT: begin
        if (!full_rel[other]) begin
          wr_bank_d = other;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    wr_ready_d = (state_d == FILL);
    addr_err_d = (wr_acc & wr_oor) | (rd_en & rd_oor);
  end

  // Bank pointers, flags, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      drop_cnt  <= '0;
      wr_ready  <= 1'b1;
      addr_err  <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      drop_cnt  <= drop_d;
      wr_ready  <= wr_ready_d;
      addr_err  <= addr_err_d;
      rd_valid  <= rd_en;
    end
  end

  // Out-of-range reads clear the read register instead of touching the array.
  dp_ram_sync #(
    .DATA_W (DATA_W),
    .WORDS  (2 * DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc & ~wr_oor),
    .waddr ({wr_bank_q, wr_addr}),
    .wdata (wr_data),
    .re    (rd_en & ~rd_oor),
    .rclr  (rd_en & rd_oor),
    .raddr ({rd_bank_q, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong: one instance per overflow policy, shared
// stimulus, each checked every cycle against a frame-level reference model.
module tb_frame_buffer_pingpong;

  localparam int unsigned H     = 6;
  localparam int unsigned V     = 4;
  localparam int unsigned DEPTH = H * V;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_frame_done = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_frame_done = 1'b0;

  logic [1:0]    wr_ready, rd_valid, frame_avail, addr_err;
  logic [DW-1:0] rd_data [2];
  logic [15:0]   drop_cnt [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.DATA_W(DW), .H_PIXELS(H), .V_PIXELS(V), .DROP_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(wr_ready[0]), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .rd_frame_done(rd_frame_done), .frame_avail(frame_avail[0]),
    .addr_err(addr_err[0]), .drop_cnt(drop_cnt[0])
  );

  frame_buffer_pingpong #(.DATA_W(DW), .H_PIXELS(H), .V_PIXELS(V), .DROP_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(wr_ready[1]), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .rd_frame_done(rd_frame_done), .frame_avail(frame_avail[1]),
    .addr_err(addr_err[1]), .drop_cnt(drop_cnt[1])
  );

  // Reference model, index 0 = stalling policy, 1 = dropping policy.
  logic [DW-1:0] m_mem [2][2][DEPTH];
  bit            m_wv  [2][2][DEPTH];
  bit            m_full [2][2];
  int            m_wb [2];
  int            m_rb [2];
  bit            m_wait [2];
  int            m_drop [2];
  logic [DW-1:0] m_rdata [2];
  bit            m_rknown [2];
  bit            m_rvalid [2];
  bit            m_aerr [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 2; b++) begin
        m_full[d][b] = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_wv[d][b][a] = 1'b0;
      end
      m_wb[d] = 0; m_rb[d] = 0; m_wait[d] = 1'b0; m_drop[d] = 0;
      m_rdata[d] = '0; m_rknown[d] = 1'b1; m_rvalid[d] = 1'b0; m_aerr[d] = 1'b0;
    end
  endtask

  // One clock of behaviour for instance d, using the inputs seen at the edge.
  task automatic model_tick(input int d);
    bit ready;
    int o;
    ready = !m_wait[d];
    m_aerr[d] = 1'b0;
    m_rvalid[d] = rd_en;
    if (rd_en) begin
      if (int'(rd_addr) < DEPTH) begin
        m_rdata[d]  = m_mem[d][m_rb[d]][rd_addr];
        m_rknown[d] = m_wv[d][m_rb[d]][rd_addr];
      end else begin
        m_rdata[d] = '0; m_rknown[d] = 1'b1; m_aerr[d] = 1'b1;
      end
    end
    if (wr_en && ready) begin
      if (int'(wr_addr) < DEPTH) begin
        m_mem[d][m_wb[d]][wr_addr] = wr_data;
        m_wv[d][m_wb[d]][wr_addr]  = 1'b1;
      end else begin
        m_aerr[d] = 1'b1;
      end
    end
    if (rd_frame_done && m_full[d][m_rb[d]]) begin
      m_full[d][m_rb[d]] = 1'b0;
      m_rb[d] = 1 - m_rb[d];
    end
    o = 1 - m_wb[d];
    if (ready && wr_frame_done) begin
      if (!m_full[d][o]) begin
        m_full[d][m_wb[d]] = 1'b1;
        m_wb[d] = o;
      end else if (d == 0) begin
        m_full[d][m_wb[d]] = 1'b1;
        m_wait[d] = 1'b1;
      end else begin
        m_drop[d] = (m_drop[d] < 65535) ? m_drop[d] + 1 : 65535;
      end
    end else if (!ready && !m_full[d][o]) begin
      m_wb[d] = o;
      m_wait[d] = 1'b0;
    end
  endtask

  task automatic check_dut(input int d);
    check_val($sformatf("wr_ready%0d", d), 32'(wr_ready[d]), 32'(!m_wait[d]));
    check_val($sformatf("frame_avail%0d", d), 32'(frame_avail[d]), 32'(m_full[d][m_rb[d]]));
    check_val($sformatf("rd_valid%0d", d), 32'(rd_valid[d]), 32'(m_rvalid[d]));
    check_val($sformatf("addr_err%0d", d), 32'(addr_err[d]), 32'(m_aerr[d]));
    check_val($sformatf("drop_cnt%0d", d), 32'(drop_cnt[d]), 32'(m_drop[d]));
    if (m_rknown[d]) check_val($sformatf("rd_data%0d", d), 32'(rd_data[d]), 32'(m_rdata[d]));
  endtask

  // Advance one clock, update the model, compare, then drop all strobes.
  task automatic step();
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1;
    check_dut(0);
    check_dut(1);
    wr_en = 1'b0; rd_en = 1'b0; wr_frame_done = 1'b0; rd_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_frame_done = 1'b0; rd_frame_done = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst_wr_ready%0d", d), 32'(wr_ready[d]), 32'd1);
      check_val($sformatf("rst_frame_avail%0d", d), 32'(frame_avail[d]), 32'd0);
      check_val($sformatf("rst_drop_cnt%0d", d), 32'(drop_cnt[d]), 32'd0);
      check_val($sformatf("rst_rd_valid%0d", d), 32'(rd_valid[d]), 32'd0);
      check_val($sformatf("rst_rd_data%0d", d), 32'(rd_data[d]), 32'd0);
      check_val($sformatf("rst_addr_err%0d", d), 32'(addr_err[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr_px(input int a, input int v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(v);
    step();
  endtask

  task automatic rd_px(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    step();
  endtask

  task automatic wr_done();
    wr_frame_done = 1'b1;
    step();
  endtask

  task automatic rd_done();
    rd_frame_done = 1'b1;
    step();
  endtask

  initial begin
    #2;
    do_reset();

    // Read-first on a shared bank right after reset.
    wr_px(5, 8'h11);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h22; rd_en = 1'b1; rd_addr = 5'd5;
    step();
    check_val("rd_first", 32'(rd_data[0]), 32'h11);
    rd_px(5);
    check_val("rd_after_wr", 32'(rd_data[0]), 32'h22);

    // Fill and read back one frame.
    do_reset();
    for (int i = 0; i < 16; i++) wr_px(i, i);
    wr_done();
    check_val("t1_avail0", 32'(frame_avail[0]), 32'd1);
    check_val("t1_avail1", 32'(frame_avail[1]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_px(i);
      check_val("t1_rd", 32'(rd_data[0]), 32'(i));
    end

    // Overflow: stall vs drop.
    do_reset();
    for (int i = 0; i < 4; i++) wr_px(i, 8'hA0 + i);
    wr_done();
    for (int i = 0; i < 4; i++) wr_px(i, 8'hB0 + i);
    wr_done();
    check_val("t2_ready_stall", 32'(wr_ready[0]), 32'd0);
    check_val("t3_ready_drop", 32'(wr_ready[1]), 32'd1);
    check_val("t3_drop_cnt", 32'(drop_cnt[1]), 32'd1);
    check_val("t2_drop_cnt", 32'(drop_cnt[0]), 32'd0);
    for (int i = 0; i < 4; i++) wr_px(i, 8'hC0 + i);
    for (int i = 0; i < 4; i++) begin
      rd_px(i);
      check_val("t23_rd0", 32'(rd_data[0]), 32'(8'hA0 + i));
      check_val("t23_rd1", 32'(rd_data[1]), 32'(8'hA0 + i));
    end
    rd_done();
    check_val("t2_ready_resume", 32'(wr_ready[0]), 32'd1);
    check_val("t2_avail", 32'(frame_avail[0]), 32'd1);
    check_val("t3_avail", 32'(frame_avail[1]), 32'd0);
    rd_px(0);
    check_val("t2_bank1", 32'(rd_data[0]), 32'hB0);
    check_val("t3_bank1", 32'(rd_data[1]), 32'hC0);

    // Simultaneous writer and reader handoff.
    do_reset();
    for (int i = 0; i < 4; i++) wr_px(i, 8'h10 + i);
    wr_done();
    for (int i = 0; i < 4; i++) wr_px(i, 8'h20 + i);
    wr_frame_done = 1'b1; rd_frame_done = 1'b1;
    step();
    check_val("t4_ready0", 32'(wr_ready[0]), 32'd1);
    check_val("t4_avail0", 32'(frame_avail[0]), 32'd1);
    check_val("t4_drop1", 32'(drop_cnt[1]), 32'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h55; rd_en = 1'b1; rd_addr = 5'd0;
    step();
    check_val("t4_rd_bank1", 32'(rd_data[0]), 32'h20);

    // Out-of-range accesses.
    wr_en = 1'b1; wr_addr = AW'(DEPTH); wr_data = 8'h99; rd_en = 1'b1; rd_addr = AW'(DEPTH + 3);
    step();
    check_val("t5_addr_err", 32'(addr_err[0]), 32'd1);
    check_val("t5_rd_valid", 32'(rd_valid[0]), 32'd1);
    check_val("t5_rd_data", 32'(rd_data[0]), 32'd0);
    step();
    check_val("t5_err_pulse", 32'(addr_err[0]), 32'd0);

    // Reset with both banks full and writer stalled.
    wr_done();
    check_val("t6_pre_stall", 32'(wr_ready[0]), 32'd0);
    do_reset();

    // Random traffic, with a reset in the middle.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset();
      wr_en         = ($urandom_range(1, 0) == 1);
      wr_addr       = AW'($urandom_range(31, 0));
      wr_data       = DW'($urandom);
      wr_frame_done = ($urandom_range(7, 0) == 0);
      rd_en         = ($urandom_range(1, 0) == 1);
      rd_addr       = AW'($urandom_range(31, 0));
      rd_frame_done = ($urandom_range(11, 0) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
